rf_writeback_queue: RTL

Writeback queue sitting in front of the three-read/one-write register file. It accepts register results from two producers, the ALU (port A) and the load unit (port B), and buffers them in program order. It drains exactly one entry per cycle onto the register file's single write port (we3/wa3/wd3). It also answers a pending-write lookup, so decode can forward or stall on results not yet committed.

---
 rtl/rf_writeback_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: in-order writeback buffer in front of the single
// register-file write port. It takes results from the ALU (port A) and the
// load unit (port B) and drains one entry per cycle onto we3/wa3/wd3. It also
// answers a pending-write lookup so decode can forward or stall.
module rf_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,

    input  logic              a_valid,
    output logic              a_ready,
    input  logic [4:0]        a_addr,
    input  logic [DATA_W-1:0] a_data,

    input  logic              b_valid,
    output logic              b_ready,
    input  logic [4:0]        b_addr,
    input  logic [DATA_W-1:0] b_data,

    output logic              we3,
    output logic [4:0]        wa3,
    output logic [DATA_W-1:0] wd3,

    input  logic [4:0]        q_addr,
    output logic              q_hit,
    output logic [DATA_W-1:0] q_data,

    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full
);

    // Circular storage; entries are not reset, validity comes from count.
    logic [4:0]        mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic [CW-1:0] free;
    logic          a_push;
    logic          b_push;
    logic          pop;
    logic [PW-1:0] a_idx;
    logic [CW-1:0] n_push;
    logic [CW-1:0] count_nxt;

    // Ready from registered occupancy only: a same-cycle pop never frees a slot,
    // and A needs two free slots when B is also offering (B is enqueued first).
    always_comb begin
        free    = CW'(DEPTH) - count;
        b_ready = (free >= CW'(1));
        a_ready = b_valid ? (free >= CW'(2)) : (free >= CW'(1));
    end

    // Push/pop decode; writes to r0 are accepted but dropped, flush drops all.
    always_comb begin
        b_push    = b_valid && b_ready && (b_addr != 5'd0) && !flush;
        a_push    = a_valid && a_ready && (a_addr != 5'd0) && !flush;
        pop       = (count != '0);
        a_idx     = tail + PW'(b_push);
        n_push    = CW'(a_push) + CW'(b_push);
        count_nxt = count + n_push - CW'(pop);
    end

    // ---- enqueue stage: store accepted entries, older load (B) first ----
    always_ff @(posedge clk) begin
        if (b_push) begin
            mem_addr[tail] <= b_addr;
            mem_data[tail] <= b_data;
        end
        if (a_push) begin
            mem_addr[a_idx] <= a_addr;
            mem_data[a_idx] <= a_data;
        end
    end

    // ---- drain stage: pointers, occupancy and the registered write port ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            we3   <= 1'b0;
            wa3   <= '0;
            wd3   <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            we3   <= 1'b0;
        end else begin
            tail  <= tail + PW'(n_push);
            count <= count_nxt;
            we3   <= pop;
            if (pop) begin
                head <= head + PW'(1);
                wa3  <= mem_addr[head];
                wd3  <= mem_data[head];
            end
        end
    end

    // Lookup walks oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        logic [PW-1:0] idx;
        q_hit  = 1'b0;
        q_data = '0;
        idx    = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (q_addr != 5'd0) && (mem_addr[idx] == q_addr)) begin
                q_hit  = 1'b1;
                q_data = mem_data[idx];
            end
        end
    end

    // Status flags track the registered occupancy.
    always_comb begin
        empty = (count == '0);
        full  = (count == CW'(DEPTH));
    end

endmodule
